// File: rtl/rvv_red_seq.sv
// Multi-cycle RVV reduction sequencer (vred*): folds L = 1<<NB_LANES elements per cycle into a scalar seed.
// Optional build macro RVV_RED_MASK_EN adds the vmask port and element masking under instr_mask.
module rvv_red_seq #(
  parameter logic [16:0] VLEN     = 17'd128,
  parameter int          NB_LANES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      opcode,
  input  logic [2:0]      vsew,
  input  logic [16:0]     vl,
  input  logic [VLEN-1:0] vs2,
  input  logic [31:0]     scalar_in,
  input  logic            instr_mask,
`ifdef RVV_RED_MASK_EN
  input  logic [VLEN-1:0] vmask,
`endif
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic [31:0]     result,
  output logic [16:0]     elem_idx
);

  localparam int VW   = 32'(VLEN);
  localparam int L    = 1 << NB_LANES;
  localparam int IW8  = $clog2(VW / 8);
  localparam int IW16 = $clog2(VW / 16);
  localparam int IW32 = $clog2(VW / 32);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  typedef enum logic [2:0] {
    OP_SUM, OP_AND, OP_OR, OP_XOR, OP_MINU, OP_MIN, OP_MAXU, OP_MAX
  } op_t;

  state_t          state_q, state_d;
  op_t             op_q;
  logic [1:0]      sew_q;
  logic [VLEN-1:0] vs2_q;
  logic [16:0]     n_q, n_start, vlmax;
  logic [31:0]     acc_q, acc_next;
  logic [31:0]     lvl [NB_LANES+1][L];

`ifdef RVV_RED_MASK_EN
  localparam int MW = $clog2(VW);
  logic            mask_en_q;
  logic [VLEN-1:0] vmask_q;
`else
  logic            unused_instr_mask;
  assign unused_instr_mask = instr_mask;
`endif

  function automatic logic [31:0] sew_mask(input logic [1:0] sew);
    case (sew)
      2'd0:    return 32'h0000_00FF;
      2'd1:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] sign_bit(input logic [1:0] sew);
    case (sew)
      2'd0:    return 32'h0000_0080;
      2'd1:    return 32'h0000_8000;
      default: return 32'h8000_0000;
    endcase
  endfunction

  function automatic logic [31:0] identity(input op_t op, input logic [1:0] sew);
    case (op)
      OP_AND, OP_MINU: return sew_mask(sew);
      OP_MIN:          return sew_mask(sew) >> 1;
      OP_MAX:          return sign_bit(sew);
      default:         return 32'h0;
    endcase
  endfunction

  // Operands are zero-extended SEW values; flipping the sign bit turns signed compare into unsigned.
  function automatic logic [31:0] red_op(input op_t op, input logic [1:0] sew,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] sa, sb;
    sa = a ^ sign_bit(sew);
    sb = b ^ sign_bit(sew);
    case (op)
      OP_SUM:  return (a + b) & sew_mask(sew);
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_MINU: return (a < b) ? a : b;
      OP_MIN:  return (sa < sb) ? a : b;
      OP_MAXU: return (a > b) ? a : b;
      default: return (sa > sb) ? a : b;
    endcase
  endfunction

  always_comb begin
    case (vsew)
      3'd0:    vlmax = VLEN >> 3;
      3'd1:    vlmax = VLEN >> 4;
      default: vlmax = VLEN >> 5;
    endcase
    n_start = (vl < vlmax) ? vl : vlmax;
  end

  // Lane tree: leaves are this cycle's elements (identity for tail/masked), folded pairwise.
  always_comb begin
    logic [16:0] idx;
    logic        active;
    logic [31:0] elem;
    // NOTE: every combinational variable gets a default first so no latch is inferred.
    lvl    = '{default: '0};
    idx    = '0;
    active = 1'b0;
    elem   = '0;
    for (int i = 0; i < L; i++) begin
      idx    = elem_idx + 17'(i);
      active = (idx < n_q);
`ifdef RVV_RED_MASK_EN
      if (mask_en_q && !vmask_q[idx[MW-1:0]]) active = 1'b0;
`endif
      case (sew_q)
        2'd0:    elem = {24'h0, vs2_q[{idx[IW8-1:0], 3'b000} +: 8]};
        2'd1:    elem = {16'h0, vs2_q[{idx[IW16-1:0], 4'b0000} +: 16]};
        default: elem = vs2_q[{idx[IW32-1:0], 5'b00000} +: 32];
      endcase
      lvl[0][i] = active ? elem : identity(op_q, sew_q);
    end
    for (int k = 1; k <= NB_LANES; k++) begin
      for (int i = 0; i < (L >> k); i++) begin
        lvl[k][i] = red_op(op_q, sew_q, lvl[k-1][2*i], lvl[k-1][2*i+1]);
      end
    end
    acc_next = red_op(op_q, sew_q, acc_q, lvl[NB_LANES][0]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ((vsew > 3'd2) || (n_start == '0)) ? DONE : ACCUM;
      ACCUM:   if (({1'b0, elem_idx} + 18'(L)) >= {1'b0, n_q}) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      elem_idx <= '0;
      result   <= '0;
      illegal  <= 1'b0;
      n_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          acc_q    <= scalar_in & sew_mask(vsew[1:0]);
          elem_idx <= '0;
          n_q      <= n_start;
          if (vsew > 3'd2) begin
            result  <= '0;
            illegal <= 1'b1;
          end else if (n_start == '0) begin
            result  <= scalar_in & sew_mask(vsew[1:0]);
            illegal <= 1'b0;
          end
        end
        ACCUM: begin
          acc_q    <= acc_next;
          elem_idx <= elem_idx + 17'(L);
          if (state_d == DONE) begin
            result  <= acc_next;
            illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: operand registers carry no reset; they are reloaded by every accepted start before use.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      op_q  <= op_t'(opcode);
      sew_q <= vsew[1:0];
      vs2_q <= vs2;
`ifdef RVV_RED_MASK_EN
      mask_en_q <= instr_mask;
      vmask_q   <= vmask;
`endif
    end
  end

endmodule

// File: tb/tb_rvv_red_seq.sv
// Self-checking bench for rvv_red_seq: behavioural fold model + per-cycle compare, directed literals, random traffic.
module tb_rvv_red_seq;

  localparam int VLEN     = 128;
  localparam int NB_LANES = 1;
  localparam int L        = 1 << NB_LANES;
`ifdef RVV_RED_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, start, instr_mask;
  logic [2:0]      opcode, vsew;
  logic [16:0]     vl;
  logic [VLEN-1:0] vs2, vmask;
  logic [31:0]     scalar_in;
  logic            busy, done, illegal;
  logic [31:0]     result;
  logic [16:0]     elem_idx;

  int n_tests = 0;
  int n_fail  = 0;

  rvv_red_seq #(.VLEN(17'(VLEN)), .NB_LANES(NB_LANES)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .opcode     (opcode),
    .vsew       (vsew),
    .vl         (vl),
    .vs2        (vs2),
    .scalar_in  (scalar_in),
    .instr_mask (instr_mask),
`ifdef RVV_RED_MASK_EN
    .vmask      (vmask),
`endif
    .busy       (busy),
    .done       (done),
    .illegal    (illegal),
    .result     (result),
    .elem_idx   (elem_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Straight sequential fold over active elements, as the instruction is defined.
  function automatic void model(input logic [2:0] op, input logic [2:0] sew, input logic [16:0] vlen_req,
                                input logic [VLEN-1:0] v, input logic [31:0] seed, input logic im,
                                input logic [VLEN-1:0] vm, output logic [31:0] r, output logic il,
                                output int lat);
    longint w, mask, sb, n, acc, e;
    logic [VLEN-1:0] sh;
    if (sew > 3'd2) begin
      r = '0; il = 1'b1; lat = 1;
      return;
    end
    w    = 64'(8) << sew;
    mask = (64'sd1 << w) - 1;
    sb   = 64'sd1 << (w - 1);
    n    = VLEN / w;
    if (longint'(vlen_req) < n) n = longint'(vlen_req);
    acc  = longint'(seed) & mask;
    for (longint i = 0; i < n; i++) begin
      if (MASK_EN && im && !vm[i]) continue;
      sh = v >> (i * w);
      e  = longint'(sh[31:0]) & mask;
      case (op)
        3'd0: acc = (acc + e) & mask;
        3'd1: acc = acc & e;
        3'd2: acc = acc | e;
        3'd3: acc = acc ^ e;
        3'd4: if (e < acc) acc = e;
        3'd5: if (((e ^ sb) - sb) < ((acc ^ sb) - sb)) acc = e;
        3'd6: if (e > acc) acc = e;
        default: if (((e ^ sb) - sb) > ((acc ^ sb) - sb)) acc = e;
      endcase
    end
    r   = 32'(acc);
    il  = 1'b0;
    lat = (n == 0) ? 1 : int'((n + L - 1) / L) + 1;
  endfunction

  // Model timeline: phase 0 = idle, 1..m_lat = cycles after acceptance, m_lat = done cycle.
  int          m_phase = 0;
  int          m_lat   = 1;
  logic [31:0] m_res   = '0;
  logic [31:0] m_pres  = '0;
  logic        m_ill   = 1'b0;
  logic        m_pill  = 1'b0;

  always @(posedge clk) begin
    logic [31:0] r;
    logic        il;
    int          lat;
    if (reset) begin
      m_phase <= 0;
      m_res   <= '0;
      m_ill   <= 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        model(opcode, vsew, vl, vs2, scalar_in, instr_mask, vmask, r, il, lat);
        m_phase <= 1;
        m_lat   <= lat;
        m_pres  <= r;
        m_pill  <= il;
        if (lat == 1) begin
          m_res <= r;
          m_ill <= il;
        end
      end
    end else if (m_phase == m_lat) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
      if (m_phase + 1 == m_lat) begin
        m_res <= m_pres;
        m_ill <= m_pill;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("done", 32'(done), 32'(m_phase != 0 && m_phase == m_lat));
    check("result", result, m_res);
    if (m_phase != 0 && m_phase == m_lat) check("illegal", 32'(illegal), 32'(m_ill));
    if (m_phase != 0 && m_phase < m_lat) check("elem_idx", 32'(elem_idx), 32'((m_phase - 1) * L));
  end

  function automatic logic [VLEN-1:0] pack32(input logic [31:0] a, b, c, d);
    logic [VLEN-1:0] v;
    v = '0;
    v[31:0] = a; v[63:32] = b; v[95:64] = c; v[127:96] = d;
    return v;
  endfunction

  // Called at a negedge while idle; returns at the first idle negedge after done.
  task automatic do_op(input logic [2:0] op, input logic [2:0] sew, input logic [16:0] n_el,
                       input logic [VLEN-1:0] v, input logic [31:0] seed, input logic im,
                       input logic [VLEN-1:0] vm, output logic [31:0] r, output logic il,
                       output int lat);
    opcode = op; vsew = sew; vl = n_el; vs2 = v; scalar_in = seed;
    instr_mask = im; vmask = vm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", 32'(done), 32'd1);
    r  = result;
    il = illegal;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0]     r;
    logic            il;
    int              lat;
    logic [VLEN-1:0] v8;

    reset = 1'b1; start = 1'b0; opcode = '0; vsew = '0; vl = '0;
    vs2 = '0; scalar_in = '0; instr_mask = 1'b0; vmask = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_elem_idx", 32'(elem_idx), 32'd0);

    do_op(3'd0, 3'd2, 17'd4, pack32(1, 2, 3, 4), 32'd10, 1'b0, '0, r, il, lat);
    check("sum_result", r, 32'd20);
    check("sum_latency", 32'(lat), 32'd3);
    check("sum_illegal", 32'(il), 32'd0);

    v8 = '0;
    for (int i = 0; i < 16; i++) v8[i*8 +: 8] = 8'h05;
    v8[7*8 +: 8] = 8'hFE;
    do_op(3'd5, 3'd0, 17'd16, v8, 32'h03, 1'b0, '0, r, il, lat);
    check("min_result", r, 32'h0000_00FE);
    check("min_latency", 32'(lat), 32'd9);
    do_op(3'd4, 3'd0, 17'd16, v8, 32'h03, 1'b0, '0, r, il, lat);
    check("minu_result", r, 32'h0000_0003);

    do_op(3'd1, 3'd1, 17'd0, pack32(1, 2, 3, 4), 32'h1234_5678, 1'b0, '0, r, il, lat);
    check("vl0_result", r, 32'h0000_5678);
    check("vl0_latency", 32'(lat), 32'd1);
    check("vl0_illegal", 32'(il), 32'd0);
    do_op(3'd0, 3'd3, 17'd4, pack32(1, 2, 3, 4), 32'h1234_5678, 1'b0, '0, r, il, lat);
    check("badsew_result", r, 32'd0);
    check("badsew_illegal", 32'(il), 32'd1);
    check("badsew_latency", 32'(lat), 32'd1);

    do_op(3'd3, 3'd2, 17'd3, pack32(32'hF0, 32'h0F, 32'hFF, 32'hAA), 32'd0, 1'b0, '0, r, il, lat);
    check("xor_tail_result", r, 32'd0);
    check("xor_tail_latency", 32'(lat), 32'd3);

    do_op(3'd0, 3'd2, 17'd4, pack32(1, 2, 3, 4), 32'd0, 1'b1, 128'b0101, r, il, lat);
    check("masked_sum", r, MASK_EN ? 32'd4 : 32'd10);
    do_op(3'd0, 3'd2, 17'd4, pack32(1, 2, 3, 4), 32'd0, 1'b0, 128'b0101, r, il, lat);
    check("unmasked_sum", r, 32'd10);
    do_op(3'd0, 3'd2, 17'd4, pack32(1, 2, 3, 4), 32'd77, 1'b1, '0, r, il, lat);
    check("all_masked", r, MASK_EN ? 32'd77 : 32'd87);

    do_op(3'd0, 3'd2, 17'd100, pack32(1, 2, 3, 4), 32'd0, 1'b0, '0, r, il, lat);
    check("vl_clamp_result", r, 32'd10);
    check("vl_clamp_latency", 32'(lat), 32'd3);
    do_op(3'd7, 3'd2, 17'd4, pack32(32'h8000_0000, 32'h7FFF_FFFF, 1, 0), 32'h8000_0000, 1'b0, '0, r, il, lat);
    check("max_result", r, 32'h7FFF_FFFF);
    do_op(3'd6, 3'd2, 17'd4, pack32(32'h8000_0000, 32'h7FFF_FFFF, 1, 0), 32'd0, 1'b0, '0, r, il, lat);
    check("maxu_result", r, 32'h8000_0000);
    do_op(3'd0, 3'd0, 17'd16, {VLEN{1'b1}}, 32'h1, 1'b0, '0, r, il, lat);
    check("sum_wrap", r, 32'h0000_00F1);

    // Start held through the done cycle is not accepted.
    opcode = 3'd0; vsew = 3'd2; vl = 17'd0; scalar_in = 32'd7; start = 1'b1;
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    scalar_in = 32'd9;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_ignored", 32'(busy), 32'd0);
    check("start_in_done_result", result, 32'd7);
    @(negedge clk);

    // Reset mid-ACCUM with start held high.
    opcode = 3'd5; vsew = 3'd0; vl = 17'd16; vs2 = v8; scalar_in = 32'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_accum_busy", 32'(busy), 32'd1);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_elem_idx", 32'(elem_idx), 32'd0);
    @(negedge clk);
    check("rst_mid_no_done", 32'(done), 32'd0);
    do_op(3'd0, 3'd2, 17'd4, pack32(1, 2, 3, 4), 32'd10, 1'b0, '0, r, il, lat);
    check("after_rst_result", r, 32'd20);

    // Random traffic: the per-cycle compare process against the model does the checking.
    for (int c = 0; c < 3000; c++) begin
      start      = ($urandom_range(0, 3) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      opcode     = 3'($urandom_range(0, 7));
      vsew       = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0:       vl = 17'd0;
        1:       vl = 17'($urandom_range(1, 20));
        2:       vl = 17'($urandom_range(0, 70));
        default: vl = 17'($urandom);
      endcase
      for (int w = 0; w < VLEN / 32; w++) begin
        vs2[w*32 +: 32]   = $urandom;
        vmask[w*32 +: 32] = $urandom;
      end
      if ($urandom_range(0, 3) == 0) vs2[31:0] = 32'h8000_0000;
      scalar_in  = $urandom;
      instr_mask = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0; reset = 1'b0;
    for (int c = 0; c < 100 && busy; c++) @(negedge clk);
    check("final_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
